// File: rtl/gray_hist_binner_if.sv
// Pixel-stream and histogram-result bundle for gray_hist_binner.
// The master drives pixels and vsync; the slave (the binner) returns the bar heights.
interface gray_hist_binner_if;
    logic         pix_valid;
    logic [3:0]   pix_gray;
    logic         vsync;
    logic [127:0] bar_heights;
    logic         bar_valid;
    logic         drop_flag;
    logic         busy;

    modport master (
        output pix_valid, pix_gray, vsync,
        input  bar_heights, bar_valid, drop_flag, busy
    );

    modport slave (
        input  pix_valid, pix_gray, vsync,
        output bar_heights, bar_valid, drop_flag, busy
    );
endinterface

// File: rtl/gray_hist_binner.sv
// 16-bin luminance histogram over an UPDATE_FRAMES window, scaled to bar heights
// and handed to the overlay stage as one atomic 128-bit update.
module gray_hist_binner #(
    parameter int UPDATE_FRAMES = 10,
    parameter int CNT_W         = 22,
    parameter int SHIFT         = 14,
    parameter int BAR_MAX       = 200
) (
    input logic               clk,
    input logic               reset,
    gray_hist_binner_if.slave hist
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DRAIN   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    localparam int              FC_W    = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(UPDATE_FRAMES - 1);

    // The ceiling is applied to the full-width shifted count so large counts never alias
    function automatic logic [7:0] scale_bin(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] shifted;
        shifted = cnt >> SHIFT;
        if (shifted > CNT_W'(BAR_MAX)) begin
            scale_bin = 8'(BAR_MAX);
        end else begin
            scale_bin = shifted[7:0];
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic               vsync_d_r;
    logic [FC_W-1:0]    frame_cnt_r;
    logic [3:0]         idx_r;
    logic [CNT_W-1:0]   bin_r [16];
    logic [127:0]       shadow_r;
    logic [127:0]       shadow_nxt_s;
    logic [127:0]       bar_heights_r;
    logic               bar_valid_r;
    logic               drop_flag_r;
    logic               busy_r;

    logic               boundary_s;
    logic               last_frame_s;
    logic               accum_s;
    logic               drain_s;
    logic               drain_last_s;
    logic               count_s;
    logic               drop_s;

    assign boundary_s   = vsync_d_r & ~hist.vsync;
    assign last_frame_s = (frame_cnt_r == FC_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (boundary_s && last_frame_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DRAIN: begin
                if (idx_r == 4'd15) begin
                    state_nxt_s = PUBLISH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            PUBLISH: state_nxt_s = ACCUM;
            default: state_nxt_s = ACCUM;
        endcase
    end

    // FSM output decode
    always_comb begin
        accum_s = 1'b0;
        drain_s = 1'b0;
        case (state_r)
            ACCUM:   accum_s = 1'b1;
            DRAIN:   drain_s = 1'b1;
            PUBLISH: accum_s = 1'b0;
            default: accum_s = 1'b0;
        endcase
        drain_last_s = drain_s & (idx_r == 4'd15);
        count_s      = accum_s & hist.pix_valid;
        drop_s       = ~accum_s & hist.pix_valid;
    end

    // Shadow image with the bin currently being drained already folded in
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (drain_s) begin
            shadow_nxt_s[{idx_r, 3'b000} +: 8] = scale_bin(bin_r[idx_r]);
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Vsync edge tracking, frame counting and drain index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d_r   <= 1'b1;
            frame_cnt_r <= '0;
            idx_r       <= 4'd0;
        end else begin
            vsync_d_r <= hist.vsync;
            if (accum_s && boundary_s) begin
                frame_cnt_r <= last_frame_s ? '0 : frame_cnt_r + FC_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            idx_r <= drain_s ? idx_r + 4'd1 : 4'd0;
        end
    end

    // Bin counters: saturating increment while accumulating, cleared as they drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                bin_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (drain_s && (idx_r == 4'(k))) begin
                    bin_r[k] <= '0;
                end else if (count_s && (hist.pix_gray == 4'(k)) && (bin_r[k] != CNT_MAX)) begin
                    bin_r[k] <= bin_r[k] + CNT_W'(1);
                end else begin
                    bin_r[k] <= bin_r[k];
                end
            end
        end
    end

    // Shadow heights and registered outputs; heights land together with the valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r      <= '0;
            bar_heights_r <= '0;
            bar_valid_r   <= 1'b0;
            drop_flag_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            shadow_r      <= shadow_nxt_s;
            bar_heights_r <= drain_last_s ? shadow_nxt_s : bar_heights_r;
            bar_valid_r   <= drain_last_s;
            drop_flag_r   <= drop_flag_r | drop_s;
            busy_r        <= (state_nxt_s == DRAIN);
        end
    end

    assign hist.bar_heights = bar_heights_r;
    assign hist.bar_valid   = bar_valid_r;
    assign hist.drop_flag   = drop_flag_r;
    assign hist.busy        = busy_r;

endmodule

// File: tb/tb_gray_hist_binner.sv
// Directed bench: instance A (UPDATE_FRAMES=2, SHIFT=4) and instance B
// (UPDATE_FRAMES=1, SHIFT=0, BAR_MAX=200) share clock and reset.
module tb_gray_hist_binner;

    typedef struct {
        int           sel;
        int           g0;
        int           n0;
        int           g1;
        int           n1;
        logic [127:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    logic pv;
    logic [3:0] pg;
    logic vs;
    int   sel;
    int   tests;
    int   fails;
    int   pulses_a;
    int   pulses_b;

    gray_hist_binner_if ifa ();
    gray_hist_binner_if ifb ();

    assign ifa.pix_valid = (sel == 0) && pv;
    assign ifb.pix_valid = (sel == 1) && pv;
    assign ifa.pix_gray  = pg;
    assign ifb.pix_gray  = pg;
    assign ifa.vsync     = (sel == 0) ? vs : 1'b1;
    assign ifb.vsync     = (sel == 1) ? vs : 1'b1;

    gray_hist_binner #(.UPDATE_FRAMES(2), .CNT_W(22), .SHIFT(4), .BAR_MAX(200)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hist  (ifa)
    );

    gray_hist_binner #(.UPDATE_FRAMES(1), .CNT_W(22), .SHIFT(0), .BAR_MAX(200)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hist  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifa.bar_valid) pulses_a <= pulses_a + 1;
        if (ifb.bar_valid) pulses_b <= pulses_b + 1;
    end

    function automatic logic [127:0] mk(input int b0, input int v0, input int b1, input int v1);
        logic [127:0] r;
        r = '0;
        r[b0*8 +: 8] = 8'(v0);
        r[b1*8 +: 8] = 8'(v1);
        return r;
    endfunction

    function automatic logic cur_valid();
        return (sel == 1) ? ifb.bar_valid : ifa.bar_valid;
    endfunction

    function automatic logic [127:0] cur_heights();
        return (sel == 1) ? ifb.bar_heights : ifa.bar_heights;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_pix(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pv = 1'b1;
            pg = 4'(g);
        end
        @(negedge clk);
        pv = 1'b0;
    endtask

    task automatic mid_boundary();
        @(negedge clk);
        vs = 1'b0;
        pv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
    endtask

    // Final boundary of a window, then wait for the publish and check it
    task automatic close_and_check(input string name, input logic [127:0] exp,
                                   input bit bpix, input int bg, input bit drop_en);
        int lat;
        logic [127:0] got;
        lat = -1;
        got = '0;
        @(negedge clk);
        vs = 1'b0;
        pv = bpix;
        pg = 4'(bg);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 2) vs = 1'b1;
            pv = drop_en && (j <= 17);
            pg = 4'(bg);
            if (cur_valid()) begin
                lat = j;
                got = cur_heights();
                break;
            end
        end
        check({name, " latency"}, 128'(lat), 128'(17));
        check({name, " heights"}, got, exp);
        @(negedge clk);
        pv = 1'b0;
        vs = 1'b1;
        check({name, " pulse width"}, 128'(cur_valid()), 128'(0));
        @(negedge clk);
    endtask

    task automatic expect_quiet(input string name, input int ncyc);
        int p0;
        p0 = pulses_a + pulses_b;
        repeat (ncyc) @(negedge clk);
        check(name, 128'(pulses_a + pulses_b), 128'(p0));
    endtask

    task automatic check_zero(input string name);
        check({name, " heights"}, cur_heights(), '0);
        check({name, " valid"}, 128'(cur_valid()), 128'(0));
        check({name, " busy"}, 128'((sel == 1) ? ifb.busy : ifa.busy), 128'(0));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        tests    = 0;
        fails    = 0;
        pulses_a = 0;
        pulses_b = 0;
        sel      = 0;
        reset    = 1'b1;
        pv       = 1'b0;
        pg       = 4'd0;
        vs       = 1'b1;

        vecs[0] = '{0,  5, 1000,  0,   0, mk(5, 125,  0,   0)};
        vecs[1] = '{1,  0,  300, 15,   7, mk(0, 200, 15,   7)};
        vecs[2] = '{1,  3,  200,  9,  45, mk(3, 200,  9,  45)};
        vecs[3] = '{1,  3,  201, 12, 255, mk(3, 200, 12, 200)};
        vecs[4] = '{0,  0,   16, 15,  15, mk(0,   2, 15,   1)};
        vecs[5] = '{0,  7,    3,  8,   8, mk(7,   0,  8,   1)};

        repeat (3) @(negedge clk);
        check_zero("reset A");
        check("reset drop A", 128'(ifa.drop_flag), 128'(0));
        check("reset drop B", 128'(ifb.drop_flag), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-stream on A after one frame of a two-frame window
        sel = 0;
        send_pix(5, 100);
        mid_boundary();
        send_pix(9, 40);
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset midstream");
        @(negedge clk);
        reset = 1'b0;
        send_pix(2, 32);
        mid_boundary();
        expect_quiet("no publish after one frame", 25);
        send_pix(2, 32);
        close_and_check("fresh window A", mk(2, 4, 0, 0), 1'b0, 0, 1'b0);

        for (int v = 0; v < 6; v++) begin
            string nm;
            int frames;
            nm = $sformatf("vec%0d", v);
            sel = vecs[v].sel;
            frames = (sel == 1) ? 1 : 2;
            for (int f = 0; f < frames - 1; f++) begin
                send_pix(vecs[v].g0, vecs[v].n0);
                send_pix(vecs[v].g1, vecs[v].n1);
                mid_boundary();
            end
            send_pix(vecs[v].g0, vecs[v].n0);
            send_pix(vecs[v].g1, vecs[v].n1);
            close_and_check(nm, vecs[v].exp, 1'b0, 0, 1'b0);
        end

        // Pixel in the boundary-detect cycle belongs to the closing window
        sel = 1;
        close_and_check("boundary pixel", mk(3, 1, 0, 0), 1'b1, 3, 1'b0);
        close_and_check("empty after boundary pixel", '0, 1'b0, 0, 1'b0);

        // Pixels during DRAIN/PUBLISH are dropped and flagged
        check("drop flag before", 128'(ifb.drop_flag), 128'(0));
        send_pix(4, 10);
        close_and_check("drop window", mk(4, 10, 0, 0), 1'b0, 4, 1'b1);
        check("drop flag set", 128'(ifb.drop_flag), 128'(1));
        send_pix(4, 3);
        close_and_check("after drop", mk(4, 3, 0, 0), 1'b0, 0, 1'b0);
        check("drop flag sticky", 128'(ifb.drop_flag), 128'(1));

        // Reset while draining index 8
        send_pix(11, 50);
        @(negedge clk);
        vs = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j == 2) vs = 1'b1;
        end
        check("busy before drain reset", 128'(ifb.busy), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        check_zero("drain reset");
        check("drain reset drop", 128'(ifb.drop_flag), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        expect_quiet("no publish after drain reset", 25);
        send_pix(11, 20);
        close_and_check("fresh after drain reset", mk(11, 20, 0, 0), 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
